segasys1_hiscore_ctrl: RTL and testbench

//  Initiator for the SEGA System 1 hiscore port (HSAD/HSDO/HSDI/HSWE/PAUSE_N): copies a

---
 rtl/segasys1_hiscore_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_segasys1_hiscore_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/segasys1_hiscore_ctrl.sv
// segasys1_hiscore_ctrl: copies a game-RAM window to/from an internal byte buffer over the
// SEGA System 1 hiscore port. Define HISCORE_CKSUM_EN to build the byte checksum on CKSUM.
module segasys1_hiscore_ctrl #(
  parameter logic [15:0] BASE   = 16'hC000,
  parameter int unsigned LEN    = 256,
  parameter int unsigned BUF_AW = 8,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned SETTLE = 4
) (
  input  logic              CLK40M,
  input  logic              RESET_N,
  input  logic              SAVE_REQ,
  input  logic              LOAD_REQ,
  output logic              BUSY,
  output logic              DONE,
  output logic              PAUSE_N,
  output logic [15:0]       HSAD,
  input  logic [7:0]        HSDO,
  output logic [7:0]        HSDI,
  output logic              HSWE,
  input  logic [BUF_AW-1:0] BUF_AD,
  input  logic [7:0]        BUF_DI,
  input  logic              BUF_WE,
  output logic [7:0]        BUF_DO,
  output logic [7:0]        CKSUM
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 16;
  localparam int unsigned DEPTH = 1 << BUF_AW;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAVE, S_LOAD, S_FIN} state_e;

  state_e            state_q, state_d;
  logic              op_save_q, op_save_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       hsad_q, hsad_d;
  logic [7:0]        hsdi_q, hsdi_d;
  logic              hswe_q, hswe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pause_n_q, pause_n_d;
  logic [7:0]        buf_do_q, buf_do_d;
  logic [7:0]        mem [DEPTH];
  logic [BUF_AW-1:0] buf_ix_c;
  logic [7:0]        eng_rd_c;
  logic              last_c;
  logic              save_wr_c;

  assign buf_ix_c = idx_q[BUF_AW-1:0];
  assign eng_rd_c = mem[buf_ix_c];
  assign last_c   = (idx_q == IDX_W'(LEN - 1));

  // Sequencer; outputs are registered from the next-state view so they line up with the state.
  always_comb begin
    state_d   = state_q;
    op_save_d = op_save_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    hsad_d    = hsad_q;
    hsdi_d    = hsdi_q;
    save_wr_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (SAVE_REQ || LOAD_REQ) begin
          state_d   = S_SETTLE;
          op_save_d = SAVE_REQ;
          cnt_d     = '0;
          idx_d     = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          cnt_d = '0;
          idx_d = '0;
          if (LEN == 0)       state_d = S_FIN;
          else if (op_save_q) state_d = S_SAVE;
          else                state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SAVE: begin
        if (cnt_q == CNT_W'(RD_LAT)) begin
          save_wr_c = 1'b1;
          cnt_d     = '0;
          if (last_c) state_d = S_FIN;
          else        idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        case (cnt_q)
          CNT_W'(0): begin
            hsdi_d = eng_rd_c;
            cnt_d  = CNT_W'(1);
          end
          CNT_W'(1): cnt_d = CNT_W'(2);
          default: begin
            cnt_d = '0;
            if (last_c) state_d = S_FIN;
            else        idx_d   = idx_q + IDX_W'(1);
          end
        endcase
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d == S_SETTLE) || (state_d == S_SAVE) || (state_d == S_LOAD);
    pause_n_d = ~busy_d;
    done_d    = (state_d == S_FIN);
    hswe_d    = (state_d == S_LOAD) && (cnt_d == CNT_W'(1));
    if ((state_d == S_SAVE) || (state_d == S_LOAD)) hsad_d = BASE + idx_d;
    buf_do_d  = mem[BUF_AD];
  end

  always_ff @(posedge CLK40M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      op_save_q <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      hsad_q    <= BASE;
      hsdi_q    <= '0;
      hswe_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pause_n_q <= 1'b1;
      buf_do_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_save_q <= op_save_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      hsad_q    <= hsad_d;
      hsdi_q    <= hsdi_d;
      hswe_q    <= hswe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pause_n_q <= pause_n_d;
      buf_do_q  <= buf_do_d;
    end
  end

  // Buffer contents survive reset; the engine owns the write port while busy.
  always_ff @(posedge CLK40M) begin
    if (save_wr_c)               mem[buf_ix_c] <= HSDO;
    else if (BUF_WE && !busy_q)  mem[BUF_AD]   <= BUF_DI;
  end

`ifdef HISCORE_CKSUM_EN
  logic [7:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if ((state_q == S_IDLE) && (SAVE_REQ || LOAD_REQ))      cksum_d = '0;
    else if (save_wr_c)                                      cksum_d = cksum_q + HSDO;
    else if ((state_q == S_LOAD) && (cnt_q == CNT_W'(0)))    cksum_d = cksum_q + eng_rd_c;
  end

  always_ff @(posedge CLK40M or negedge RESET_N) begin
    if (!RESET_N) cksum_q <= '0;
    else          cksum_q <= cksum_d;
  end

  assign CKSUM = cksum_q;
`else
  assign CKSUM = 8'h00;
`endif

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PAUSE_N = pause_n_q;
  assign HSAD    = hsad_q;
  assign HSDI    = hsdi_q;
  assign HSWE    = hswe_q;
  assign BUF_DO  = buf_do_q;

endmodule

// File: tb/tb_segasys1_hiscore_ctrl.sv
// tb_segasys1_hiscore_ctrl: randomized scoreboard bench for the hiscore copy engine, with a
// game-RAM model behind the port and a second zero-length instance.
module tb_segasys1_hiscore_ctrl;

  localparam logic [15:0] BASE   = 16'hFFFE;
  localparam int          LEN    = 6;
  localparam int          BUF_AW = 3;
  localparam int          RD_LAT = 2;
  localparam int          SETTLE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, save_req, load_req, busy, done, pause_n, hswe, buf_we;
  logic [15:0]       hsad;
  logic [7:0]        hsdo, hsdi, buf_di, buf_do, cksum;
  logic [BUF_AW-1:0] buf_ad;

  logic              z_save, z_load, z_busy, z_done, z_pause_n, z_hswe;
  logic [15:0]       z_hsad;
  logic [7:0]        z_hsdi, z_buf_do, z_cksum;
  logic [7:0]        z_hsdo   = 8'h5A;
  logic [BUF_AW-1:0] z_buf_ad = '0;
  logic [7:0]        z_buf_di = '0;
  logic              z_buf_we = 1'b0;

  segasys1_hiscore_ctrl #(.BASE(BASE), .LEN(LEN), .BUF_AW(BUF_AW), .RD_LAT(RD_LAT), .SETTLE(SETTLE)) u_dut (
    .CLK40M(clk), .RESET_N(rst_n), .SAVE_REQ(save_req), .LOAD_REQ(load_req),
    .BUSY(busy), .DONE(done), .PAUSE_N(pause_n), .HSAD(hsad), .HSDO(hsdo), .HSDI(hsdi),
    .HSWE(hswe), .BUF_AD(buf_ad), .BUF_DI(buf_di), .BUF_WE(buf_we), .BUF_DO(buf_do), .CKSUM(cksum)
  );

  segasys1_hiscore_ctrl #(.BASE(16'hC000), .LEN(0), .BUF_AW(BUF_AW), .RD_LAT(RD_LAT), .SETTLE(SETTLE)) u_dut0 (
    .CLK40M(clk), .RESET_N(rst_n), .SAVE_REQ(z_save), .LOAD_REQ(z_load),
    .BUSY(z_busy), .DONE(z_done), .PAUSE_N(z_pause_n), .HSAD(z_hsad), .HSDO(z_hsdo), .HSDI(z_hsdi),
    .HSWE(z_hswe), .BUF_AD(z_buf_ad), .BUF_DI(z_buf_di), .BUF_WE(z_buf_we), .BUF_DO(z_buf_do), .CKSUM(z_cksum)
  );

  // Reference state and the game RAM seen by the DUT
  logic [7:0]  game_ram [0:65535];
  logic [7:0]  ref_ram  [0:65535];
  logic [7:0]  bufm     [0:LEN-1];
  logic [15:0] ad_pipe  [0:RD_LAT-1];
  bit          ram_init = 1'b0;
  logic        host_rd, rd_q;
  int          cyc = 0, n_cmp = 0, n_bad = 0, n_wr = 0, n_done = 0, z_done_n = 0;

  logic [15:0] wr_ad_q[$];
  logic [7:0]  wr_d_q[$], done_ck_q[$], rd_exp_q[$];
  int          done_cyc_q[$], z_done_cyc_q[$];
  string       post_nm[$];
  logic [31:0] post_act[$], post_exp[$];

  assign hsdo = game_ram[ad_pipe[RD_LAT-1]];

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rd_q       <= host_rd;
    ad_pipe[0] <= hsad;
    for (int j = 1; j < RD_LAT; j++) ad_pipe[j] <= ad_pipe[j-1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUTs present something
  always @(negedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < LEN; i++) game_ram[BASE + 16'(i)] <= ref_ram[BASE + 16'(i)];
      ram_init <= 1'b1;
    end
    while (post_nm.size() != 0) chk(post_nm.pop_front(), post_act.pop_front(), post_exp.pop_front());
    if (!rst_n) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pause_n", 32'(pause_n), 32'd1);
      chk("rst_hswe", 32'(hswe), 32'd0);
      chk("rst_hsad", 32'(hsad), 32'(BASE));
      chk("rst_hsdi", 32'(hsdi), 32'd0);
      chk("rst_cksum", 32'(cksum), 32'd0);
      chk("rst_z_pause_n", 32'(z_pause_n), 32'd1);
    end else begin
      if (hswe) begin
        n_wr <= n_wr + 1;
        game_ram[hsad] <= hsdi;
        if (wr_ad_q.size() == 0) chk("hswe_unexpected", 32'(hswe), 32'd0);
        else begin
          chk("hswe_addr", 32'(hsad), 32'(wr_ad_q.pop_front()));
          chk("hswe_data", 32'(hsdi), 32'(wr_d_q.pop_front()));
          chk("hswe_pause_n", 32'(pause_n), 32'd0);
        end
      end
      if (done) begin
        n_done <= n_done + 1;
        if (done_cyc_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
        else begin
          chk("done_cycle", 32'(cyc), 32'(done_cyc_q.pop_front()));
          chk("done_cksum", 32'(cksum), 32'(done_ck_q.pop_front()));
          chk("done_busy", 32'(busy), 32'd0);
          chk("done_pause_n", 32'(pause_n), 32'd1);
        end
      end
      if (rd_q) begin
        if (rd_exp_q.size() == 0) chk("rd_unexpected", 32'(rd_q), 32'd0);
        else chk("buf_do", 32'(buf_do), 32'(rd_exp_q.pop_front()));
      end
      if (z_hswe) chk("z_hswe", 32'(z_hswe), 32'd0);
      if (z_done) begin
        z_done_n <= z_done_n + 1;
        if (z_done_cyc_q.size() == 0) chk("z_done_unexpected", 32'(z_done), 32'd0);
        else begin
          chk("z_done_cycle", 32'(cyc), 32'(z_done_cyc_q.pop_front()));
          chk("z_cksum", 32'(z_cksum), 32'd0);
        end
      end
    end
  end

  task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
    post_nm.push_back(nm);
    post_act.push_back(act);
    post_exp.push_back(exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input int a, input logic [7:0] d);
    buf_ad = BUF_AW'(a);
    buf_di = d;
    buf_we = 1'b1;
    bufm[a] = d;
    tick();
    buf_we = 1'b0;
  endtask

  task automatic host_rd_all();
    for (int i = 0; i < LEN; i++) begin
      buf_ad  = BUF_AW'(i);
      host_rd = 1'b1;
      rd_exp_q.push_back(bufm[i]);
      tick();
    end
    host_rd = 1'b0;
    tick();
  endtask

  // One full operation: the model decides the data movement, then the request is raised
  task automatic run_op(input bit do_save, input bit both);
    int          per, nd, g;
    logic [7:0]  sum;
    logic [15:0] a;
    per = do_save ? RD_LAT + 1 : 3;
    sum = '0;
    for (int i = 0; i < LEN; i++) begin
      a = BASE + 16'(i);
      if (do_save) bufm[i] = ref_ram[a];
      else begin
        wr_ad_q.push_back(a);
        wr_d_q.push_back(bufm[i]);
        ref_ram[a] = bufm[i];
      end
      sum = sum + bufm[i];
    end
`ifdef HISCORE_CKSUM_EN
    done_ck_q.push_back(sum);
`else
    done_ck_q.push_back(8'h00);
`endif
    done_cyc_q.push_back(cyc + 1 + SETTLE + LEN * per);
    nd = n_done;
    save_req = do_save | both;
    load_req = ~do_save | both;
    tick();
    save_req = 1'b0;
    load_req = 1'b0;
    g = 0;
    while (n_done == nd && g < 2000) begin
      buf_we = (g >= 2 && g < 14) ? 1'($urandom_range(0, 1)) : 1'b0;
      buf_ad = BUF_AW'($urandom_range(0, LEN - 1));
      buf_di = 8'($urandom);
      if (g == 6) begin
        if (do_save) load_req = 1'b1;
        else         save_req = 1'b1;
      end
      if (g == 7) begin
        save_req = 1'b0;
        load_req = 1'b0;
      end
      tick();
      g++;
    end
    buf_we = 1'b0;
    post("op_done_seen", 32'(n_done != nd), 32'd1);
  endtask

  initial begin
    int w0, g, zd;
    rst_n = 1'b0; save_req = 1'b0; load_req = 1'b0; host_rd = 1'b0;
    buf_ad = '0; buf_di = '0; buf_we = 1'b0; z_save = 1'b0; z_load = 1'b0;
    for (int i = 0; i < LEN; i++) ref_ram[BASE + 16'(i)] = 8'($urandom);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    run_op(1'b1, 1'b0);                       // SAVE across the FFFF->0000 wrap
    host_rd_all();
    for (int i = 0; i < LEN; i++) host_wr(i, 8'($urandom));
    run_op(1'b0, 1'b0);                       // LOAD with a SAVE_REQ pulse mid-operation
    host_rd_all();
    for (int i = 0; i < LEN; i++) host_wr(i, 8'($urandom));
    run_op(1'b1, 1'b1);                       // both requests: SAVE wins, no write strobes
    host_rd_all();

    // Reset while the third LOAD byte is being strobed
    for (int i = 0; i < LEN; i++) host_wr(i, 8'($urandom));
    for (int i = 0; i < 2; i++) begin
      wr_ad_q.push_back(BASE + 16'(i));
      wr_d_q.push_back(bufm[i]);
      ref_ram[BASE + 16'(i)] = bufm[i];
    end
    w0 = n_wr;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    g = 0;
    while (!(hswe && n_wr == w0 + 2) && g < 300) begin
      tick();
      g++;
    end
    post("abort_point_reached", 32'(hswe && n_wr == w0 + 2), 32'd1);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    run_op(1'b0, 1'b0);                       // full LOAD after the aborted one
    run_op(1'b1, 1'b0);
    host_rd_all();

    // Zero-length instance
    zd = z_done_n;
    z_done_cyc_q.push_back(cyc + 1 + SETTLE);
    z_load = 1'b1;
    tick();
    z_load = 1'b0;
    g = 0;
    while (z_done_n == zd && g < 30) begin
      tick();
      g++;
    end
    post("z_done_seen", 32'(z_done_n != zd), 32'd1);

    repeat (8) begin
      repeat ($urandom_range(0, LEN)) host_wr($urandom_range(0, LEN - 1), 8'($urandom));
      run_op(1'($urandom_range(0, 1)), 1'b0);
      host_rd_all();
    end

    repeat (5) tick();
    post("wr_q_left", 32'(wr_ad_q.size()), 32'd0);
    post("done_q_left", 32'(done_cyc_q.size()), 32'd0);
    post("rd_q_left", 32'(rd_exp_q.size()), 32'd0);
    post("z_done_q_left", 32'(z_done_cyc_q.size()), 32'd0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
